// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RV32IM pipeline sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AWIDTH = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    FLUSH,
    MDWAIT,
    HALT
  } pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in execute whose rd feeds a source operand of the decode instruction.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_AWIDTH-1:0] dec_rs1_addr_i,
  input  logic [REG_AWIDTH-1:0] dec_rs2_addr_i,
  input  logic                  dec_uses_rs1_i,
  input  logic                  dec_uses_rs2_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_AWIDTH-1:0] ex_rd_addr_i,
  output logic                  load_use_hazard_o
);

  logic rs1_match;
  logic rs2_match;
  logic rd_live;

  // x0 is never written, so a load targeting it cannot create a dependency
  assign rd_live   = ex_mem_read_i && (ex_rd_addr_i != '0);
  assign rs1_match = dec_uses_rs1_i && (dec_rs1_addr_i == ex_rd_addr_i);
  assign rs2_match = dec_uses_rs2_i && (dec_rs2_addr_i == ex_rd_addr_i);

  assign load_use_hazard_o = rd_live && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: boot hold-off, branch flush, load-use/mul-div stalls, ebreak halt.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_COUNTERS_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES    = 2,
  parameter int unsigned FLUSH_DEPTH    = 2,
  parameter int unsigned PERF_CNT_WIDTH = 32
) (
  input  logic                      Clk_Core,
  input  logic                      Rst_Core_N,
  input  logic [REG_AWIDTH-1:0]     Dec_Rs1_Addr,
  input  logic [REG_AWIDTH-1:0]     Dec_Rs2_Addr,
  input  logic                      Dec_Uses_Rs1,
  input  logic                      Dec_Uses_Rs2,
  input  logic                      Ex_Mem_Read,
  input  logic [REG_AWIDTH-1:0]     Ex_Rd_Addr,
  input  logic                      Branch_Taken,
  input  logic                      Mul_Div_Start,
  input  logic                      Mul_Div_Done,
  input  logic                      Halt_Req,
  input  logic                      Resume,
  output logic                      Run,
  output logic                      Decode_Stall,
  output logic                      Ex_Stall,
  output logic                      Fetch_Flush,
  output logic                      Ex_Bubble,
  output logic                      Halted,
  output logic [PERF_CNT_WIDTH-1:0] Stall_Count,
  output logic [PERF_CNT_WIDTH-1:0] Flush_Count
);

  localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int unsigned FL_W   = $clog2(FLUSH_DEPTH + 1);

  pipe_state_t       state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic load_use_hazard;
  logic run_c, dec_stall_c, ex_stall_c, fetch_flush_c, ex_bubble_c, halted_c;

  pipe_ctrl_hazard_detect u_hazard_detect (
    .dec_rs1_addr_i    (Dec_Rs1_Addr),
    .dec_rs2_addr_i    (Dec_Rs2_Addr),
    .dec_uses_rs1_i    (Dec_Uses_Rs1),
    .dec_uses_rs2_i    (Dec_Uses_Rs2),
    .ex_mem_read_i     (Ex_Mem_Read),
    .ex_rd_addr_i      (Ex_Rd_Addr),
    .load_use_hazard_o (load_use_hazard)
  );

  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      state_q     <= BOOT;
      boot_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state and combinational pipe controls
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    run_c         = 1'b0;
    dec_stall_c   = 1'b0;
    ex_stall_c    = 1'b0;
    fetch_flush_c = 1'b0;
    ex_bubble_c   = 1'b0;
    halted_c      = 1'b0;

    case (state_q)
      BOOT: begin
        fetch_flush_c = 1'b1;
        if (boot_cnt_q == BOOT_W'(BOOT_CYCLES - 1)) begin
          state_d    = RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end

      RUN: begin
        // A taken branch squashes a same-cycle halt: the ebreak is on the wrong path
        if (Branch_Taken) begin
          run_c         = 1'b1;
          fetch_flush_c = 1'b1;
          ex_bubble_c   = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FL_W'(FLUSH_DEPTH - 1);
          end
        end else if (Halt_Req) begin
          dec_stall_c = 1'b1;
          ex_bubble_c = 1'b1;
          state_d     = HALT;
        end else if (Mul_Div_Start && !Mul_Div_Done) begin
          dec_stall_c = 1'b1;
          ex_stall_c  = 1'b1;
          state_d     = MDWAIT;
        end else if (load_use_hazard) begin
          dec_stall_c = 1'b1;
          ex_bubble_c = 1'b1;
        end else begin
          run_c = 1'b1;
        end
      end

      FLUSH: begin
        run_c         = 1'b1;
        fetch_flush_c = 1'b1;
        if (flush_cnt_q <= FL_W'(1)) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FL_W'(1);
        end
      end

      MDWAIT: begin
        if (Mul_Div_Done) begin
          run_c   = 1'b1;
          state_d = RUN;
        end else begin
          dec_stall_c = 1'b1;
          ex_stall_c  = 1'b1;
        end
      end

      HALT: begin
        dec_stall_c = 1'b1;
        ex_bubble_c = 1'b1;
        halted_c    = 1'b1;
        if (Resume) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign Run          = run_c;
  assign Decode_Stall = dec_stall_c;
  assign Ex_Stall     = ex_stall_c;
  assign Fetch_Flush  = fetch_flush_c;
  assign Ex_Bubble    = ex_bubble_c;
  assign Halted       = halted_c;

`ifdef PIPE_CTRL_PERF_COUNTERS_EN
  logic [PERF_CNT_WIDTH-1:0] stall_perf_q;
  logic [PERF_CNT_WIDTH-1:0] flush_perf_q;
  logic                      stall_inc;
  logic                      flush_inc;

  assign stall_inc = !run_c && (state_q != BOOT) && (state_q != HALT);
  assign flush_inc = fetch_flush_c && (state_q != BOOT);

  // Saturating event counters
  always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
    if (!Rst_Core_N) begin
      stall_perf_q <= '0;
      flush_perf_q <= '0;
    end else begin
      if (stall_inc && (stall_perf_q != '1)) begin
        stall_perf_q <= stall_perf_q + PERF_CNT_WIDTH'(1);
      end
      if (flush_inc && (flush_perf_q != '1)) begin
        flush_perf_q <= flush_perf_q + PERF_CNT_WIDTH'(1);
      end
    end
  end

  assign Stall_Count = stall_perf_q;
  assign Flush_Count = flush_perf_q;
`else
  assign Stall_Count = '0;
  assign Flush_Count = '0;
`endif

endmodule
